uart_core: RTL and testbench
============================

UART_CORE -- requirements
Module: uart_core

Interface
REQ-001 SHALL have parameter NB_UART_DATA, default 8, the data bits per frame.
REQ-002 SHALL have parameter BAUD_DIV, default 54, the clk cycles per 16x oversample tick (100 MHz / (16 x 115200)).
REQ-003 SHALL have parameter NB_BAUD_CNT, default 8, the baud counter width; it must satisfy BAUD_DIV <= 2^NB_BAUD_CNT.
REQ-004 Ports, in order:
  clk  input  1  system clock, single clock domain.
  i_rst  input  1  reset, asynchronous, active-high.
  i_wr  input  1  load i_wdata into the TX holding register.
  i_wdata  input  NB_UART_DATA  byte to transmit.
  i_tx_start  input  1  start transmitting the holding register.
  i_rd  input  1  consume the received byte (clears o_rx_done).
  i_rx  input  1  serial line in, asynchronous.
  o_tx  output  1  serial line out, idle high.
  o_tx_done  output  1  one-cycle pulse at the end of the stop bit.
  o_tx_busy  output  1  high while a frame is in flight.
  o_rx_data  output  NB_UART_DATA  last valid received byte.
  o_rx_done  output  1  level signal: an unread byte is available.
  o_rx_overrun  output  1  sticky: a byte was overwritten while unread.

Function
REQ-005 Baud counter SHALL free-run 0..BAUD_DIV-1 and emit a one-cycle tick on wrap; one bit time SHALL be 16 ticks.
REQ-006 Frame format SHALL be 8N1: start bit 0, data bits LSB first, optional parity (REQ-019), one stop bit 1.
REQ-007 TX FSM states SHALL be IDLE, START, DATA, PARITY, STOP; each non-IDLE state lasts 16 ticks; DATA lasts 16 x NB_UART_DATA ticks.
REQ-008 TX leaves IDLE to START on i_tx_start; the shift register is loaded from the holding register in that same cycle.
REQ-009 When i_wr and i_tx_start assert in the same cycle, the frame SHALL carry the new i_wdata.
REQ-010 i_tx_start while o_tx_busy=1 SHALL be ignored; i_wr while busy SHALL update only the holding register, never the frame in flight.
REQ-011 o_tx_done SHALL pulse in the cycle STOP completes, with o_tx_busy falling in that same cycle; back-to-back i_tx_start on the next cycle SHALL be accepted.
REQ-012 i_rx SHALL pass through a 2-FF synchronizer before use.
REQ-013 RX FSM states SHALL be IDLE, START, DATA, PARITY, STOP; a falling edge in IDLE enters START.
REQ-014 In START, the line is sampled at tick 7; if it is high the edge was a glitch and the FSM returns to IDLE; each subsequent bit is sampled 16 ticks after the previous sample.
REQ-015 A stop sample of 0 is a framing error: the byte SHALL be discarded, o_rx_done unchanged, and the FSM returns to IDLE.
REQ-016 On a valid stop bit, the byte SHALL load into o_rx_data and o_rx_done SHALL be set; if o_rx_done was already 1, o_rx_overrun SHALL be set.
REQ-017 i_rd SHALL clear o_rx_done next cycle; when i_rd coincides with a new byte completing, the new byte wins (o_rx_done stays 1, no overrun).

Reset
REQ-018 While i_rst is high, and immediately on assertion (asynchronous): both FSMs go to IDLE, all counters to 0, o_tx=1, o_tx_done=0, o_tx_busy=0, o_rx_data=0, o_rx_done=0, o_rx_overrun=0, synchronizer flops=1. A frame in progress SHALL be abandoned, with no partial o_tx_done or o_rx_done.

Configuration
REQ-019 With UART_PARITY_EN defined, a PARITY state SHALL carry even parity in both directions, and an RX parity mismatch SHALL discard the byte as in REQ-015. Without the macro, the PARITY state is never entered and the frame is 10 bits.

Structure
REQ-020 The shared package SHALL hold the TX/RX state encodings, OVERSAMPLE=16, and the tick-7 mid-sample constant.
REQ-021 The baud tick generator SHALL be the single sub-module uart_baud_gen, shared by TX and RX.

Verification
REQ-022 With BAUD_DIV=4: i_wr with 0xA5, then i_tx_start -> o_tx shows 0,1,0,1,0,0,1,0,1,1, each bit 64 cycles; o_tx_done pulses 640 cycles after start.
REQ-023 Loopback o_tx to i_rx, send 0x3C -> o_rx_done=1 and o_rx_data=0x3C; i_rd clears o_rx_done next cycle.
REQ-024 Drive a 20-cycle low glitch on i_rx -> RX returns to IDLE with o_rx_done=0; a frame of 0x55 with stop=0 -> discarded, o_rx_done=0.
REQ-025 Receive 0x11 then 0x22 with no i_rd -> o_rx_data=0x22, o_rx_overrun=1; i_rd on the completion cycle of a third byte -> o_rx_done stays 1.
REQ-026 Assert i_tx_start while busy -> ignored; assert i_rst mid-DATA -> o_tx=1 immediately and no o_tx_done.
REQ-027 With UART_PARITY_EN, send 0x07 -> parity bit 1 and an 11-bit frame; an injected wrong parity bit -> byte discarded.

Source files
------------

// File: rtl/uart_core_pkg.sv
// Shared definitions for uart_core: FSM state encoding and oversampling constants.
// Used by both the TX and RX state machines.
package uart_core_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 7;
  localparam int NB_TICK    = $clog2(OVERSAMPLE);

  localparam logic [NB_TICK-1:0] TICK_LAST = NB_TICK'(OVERSAMPLE - 1);
  localparam logic [NB_TICK-1:0] TICK_MID  = NB_TICK'(MID_SAMPLE);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running 16x oversample tick generator shared by the TX and RX paths.
// The counter runs 0..BAUD_DIV-1 and o_tick is high for the cycle it wraps.
module uart_baud_gen #(
  parameter int BAUD_DIV    = 54,
  parameter int NB_BAUD_CNT = 8
) (
  input  logic clk,
  input  logic i_rst,
  output logic o_tick
);

  localparam logic [NB_BAUD_CNT-1:0] CNT_LAST = NB_BAUD_CNT'(BAUD_DIV - 1);

  logic [NB_BAUD_CNT-1:0] cnt;

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + NB_BAUD_CNT'(1);
    end
  end

  assign o_tick = (cnt == CNT_LAST);

endmodule

// File: rtl/uart_core.sv
// UART transmitter/receiver with a shared baud tick, 8N1 framing by default.
// Define UART_PARITY_EN to add an even-parity bit in both directions.
module uart_core
  import uart_core_pkg::*;
#(
  parameter int NB_UART_DATA = 8,
  parameter int BAUD_DIV     = 54,
  parameter int NB_BAUD_CNT  = 8
) (
  input  logic                    clk,
  input  logic                    i_rst,
  input  logic                    i_wr,
  input  logic [NB_UART_DATA-1:0] i_wdata,
  input  logic                    i_tx_start,
  input  logic                    i_rd,
  input  logic                    i_rx,
  output logic                    o_tx,
  output logic                    o_tx_done,
  output logic                    o_tx_busy,
  output logic [NB_UART_DATA-1:0] o_rx_data,
  output logic                    o_rx_done,
  output logic                    o_rx_overrun
);

  localparam int NB_IDX = (NB_UART_DATA > 1) ? $clog2(NB_UART_DATA) : 1;
  localparam logic [NB_IDX-1:0] IDX_LAST = NB_IDX'(NB_UART_DATA - 1);

  // Handshakes are single-cycle strobes sampled on clk: i_wr loads the holding
  // register, i_tx_start is accepted only while o_tx_busy=0 (the frame takes
  // the same-cycle i_wdata if i_wr is also high), and i_rd acknowledges the
  // level o_rx_done, which a byte completing in that same cycle overrides.

  logic tick;

  uart_baud_gen #(
    .BAUD_DIV    (BAUD_DIV),
    .NB_BAUD_CNT (NB_BAUD_CNT)
  ) u_baud_gen (
    .clk    (clk),
    .i_rst  (i_rst),
    .o_tick (tick)
  );

  uart_state_t               tx_state;
  logic [NB_TICK-1:0]        tx_tick_cnt;
  logic [NB_IDX-1:0]         tx_bit_idx;
  logic [NB_UART_DATA-1:0]   tx_hold;
  logic [NB_UART_DATA-1:0]   tx_shreg;
  logic [NB_UART_DATA-1:0]   tx_load;
`ifdef UART_PARITY_EN
  logic                      tx_par;
`endif

  assign tx_load = i_wr ? i_wdata : tx_hold;

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      tx_state    <= ST_IDLE;
      tx_tick_cnt <= '0;
      tx_bit_idx  <= '0;
      tx_hold     <= '0;
      tx_shreg    <= '0;
`ifdef UART_PARITY_EN
      tx_par      <= 1'b0;
`endif
      o_tx        <= 1'b1;
      o_tx_done   <= 1'b0;
      o_tx_busy   <= 1'b0;
    end else begin
      o_tx_done <= 1'b0;
      if (i_wr) tx_hold <= i_wdata;
      case (tx_state)
        ST_IDLE: begin
          if (i_tx_start) begin
            tx_state    <= ST_START;
            tx_shreg    <= tx_load;
`ifdef UART_PARITY_EN
            tx_par      <= ^tx_load;
`endif
            tx_tick_cnt <= '0;
            tx_bit_idx  <= '0;
            o_tx        <= 1'b0;
            o_tx_busy   <= 1'b1;
          end
        end
        default: begin
          if (tick) begin
            if (tx_tick_cnt != TICK_LAST) begin
              tx_tick_cnt <= tx_tick_cnt + NB_TICK'(1);
            end else begin
              tx_tick_cnt <= '0;
              case (tx_state)
                ST_START: begin
                  tx_state <= ST_DATA;
                  o_tx     <= tx_shreg[0];
                  tx_shreg <= tx_shreg >> 1;
                end
                ST_DATA: begin
                  if (tx_bit_idx != IDX_LAST) begin
                    tx_bit_idx <= tx_bit_idx + NB_IDX'(1);
                    o_tx       <= tx_shreg[0];
                    tx_shreg   <= tx_shreg >> 1;
                  end else begin
`ifdef UART_PARITY_EN
                    tx_state <= ST_PARITY;
                    o_tx     <= tx_par;
`else
                    tx_state <= ST_STOP;
                    o_tx     <= 1'b1;
`endif
                  end
                end
                ST_PARITY: begin
                  tx_state <= ST_STOP;
                  o_tx     <= 1'b1;
                end
                default: begin
                  tx_state  <= ST_IDLE;
                  o_tx      <= 1'b1;
                  o_tx_done <= 1'b1;
                  o_tx_busy <= 1'b0;
                end
              endcase
            end
          end
        end
      endcase
    end
  end

  logic rx_meta, rx_sync, rx_sync_d, rx_fall;

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      rx_sync_d <= 1'b1;
    end else begin
      rx_meta   <= i_rx;
      rx_sync   <= rx_meta;
      rx_sync_d <= rx_sync;
    end
  end

  assign rx_fall = rx_sync_d & ~rx_sync;

  uart_state_t               rx_state;
  logic [NB_TICK-1:0]        rx_tick_cnt;
  logic [NB_IDX-1:0]         rx_bit_idx;
  logic [NB_UART_DATA-1:0]   rx_shreg;
`ifdef UART_PARITY_EN
  logic                      rx_par_ok;
`endif

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      rx_state     <= ST_IDLE;
      rx_tick_cnt  <= '0;
      rx_bit_idx   <= '0;
      rx_shreg     <= '0;
`ifdef UART_PARITY_EN
      rx_par_ok    <= 1'b0;
`endif
      o_rx_data    <= '0;
      o_rx_done    <= 1'b0;
      o_rx_overrun <= 1'b0;
    end else begin
      if (i_rd) o_rx_done <= 1'b0;
      case (rx_state)
        ST_IDLE: begin
          if (rx_fall) begin
            rx_state    <= ST_START;
            rx_tick_cnt <= '0;
          end
        end
        ST_START: begin
          // Mid-start sample; a high line here means the edge was noise.
          if (tick) begin
            if (rx_tick_cnt == TICK_MID) begin
              rx_tick_cnt <= '0;
              rx_bit_idx  <= '0;
              rx_state    <= rx_sync ? ST_IDLE : ST_DATA;
            end else begin
              rx_tick_cnt <= rx_tick_cnt + NB_TICK'(1);
            end
          end
        end
        default: begin
          if (tick) begin
            if (rx_tick_cnt != TICK_LAST) begin
              rx_tick_cnt <= rx_tick_cnt + NB_TICK'(1);
            end else begin
              rx_tick_cnt <= '0;
              case (rx_state)
                ST_DATA: begin
                  rx_shreg <= {rx_sync, rx_shreg[NB_UART_DATA-1:1]};
                  if (rx_bit_idx != IDX_LAST) begin
                    rx_bit_idx <= rx_bit_idx + NB_IDX'(1);
                  end else begin
`ifdef UART_PARITY_EN
                    rx_state <= ST_PARITY;
`else
                    rx_state <= ST_STOP;
`endif
                  end
                end
                ST_PARITY: begin
`ifdef UART_PARITY_EN
                  rx_par_ok <= (rx_sync == ^rx_shreg);
`endif
                  rx_state  <= ST_STOP;
                end
                default: begin
                  rx_state <= ST_IDLE;
`ifdef UART_PARITY_EN
                  if (rx_sync && rx_par_ok) begin
`else
                  if (rx_sync) begin
`endif
                    o_rx_data <= rx_shreg;
                    o_rx_done <= 1'b1;
                    if (o_rx_done && !i_rd) o_rx_overrun <= 1'b1;
                  end
                end
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_core.sv
// Self-checking bench for uart_core at BAUD_DIV=4 (64 clk per bit).
// Build with UART_PARITY_EN defined to exercise the parity frame as well.
module tb_uart_core;

  localparam int NB          = 8;
  localparam int BAUD_DIV    = 4;
  localparam int NB_BAUD_CNT = 8;
  localparam int BT          = 16 * BAUD_DIV;
`ifdef UART_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_wr, i_tx_start, i_rd;
  logic [NB-1:0] i_wdata;
  logic          o_tx, o_tx_done, o_tx_busy, o_rx_done, o_rx_overrun;
  logic [NB-1:0] o_rx_data;
  logic          loop_en = 1'b0;
  logic          rx_drv  = 1'b1;
  logic          rx_line;
  logic          rose;

  int n_tests = 0;
  int n_fail  = 0;

  logic [0:0]    tx_exp_q[$];
  logic [NB-1:0] rx_exp_q[$];

  assign rx_line = loop_en ? o_tx : rx_drv;

  uart_core #(
    .NB_UART_DATA (NB),
    .BAUD_DIV     (BAUD_DIV),
    .NB_BAUD_CNT  (NB_BAUD_CNT)
  ) dut (
    .clk          (clk),
    .i_rst        (rst),
    .i_wr         (i_wr),
    .i_wdata      (i_wdata),
    .i_tx_start   (i_tx_start),
    .i_rd         (i_rd),
    .i_rx         (rx_line),
    .o_tx         (o_tx),
    .o_tx_done    (o_tx_done),
    .o_tx_busy    (o_tx_busy),
    .o_rx_data    (o_rx_data),
    .o_rx_done    (o_rx_done),
    .o_rx_overrun (o_rx_overrun)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd_pulse();
    i_rd = 1'b1;
    cycles(1);
    i_rd = 1'b0;
  endtask

  // Starts a frame and checks every bit mid-bit, bit alignment and done timing.
  task automatic tx_send(input logic [NB-1:0] data, input logic use_wr, input logic rd_too,
                         input int inject_cyc, input logic [NB-1:0] inject_data);
    logic fbits [NBITS];
    int   cyc, done_cyc, t_first, j, bad_align;
    logic prev;
    fbits[0] = 1'b0;
    for (int i = 0; i < NB; i++) fbits[i+1] = data[i];
`ifdef UART_PARITY_EN
    fbits[NB+1] = ^data;
`endif
    fbits[NBITS-1] = 1'b1;
    for (int i = 0; i < NBITS; i++) tx_exp_q.push_back(fbits[i]);
    j = 1;
    while (fbits[j] == 1'b0) j++;

    i_wr       = use_wr;
    i_wdata    = use_wr ? data : ~data;
    i_tx_start = 1'b1;
    i_rd       = rd_too;
    cycles(1);
    i_wr = 1'b0; i_tx_start = 1'b0; i_rd = 1'b0;
    check("tx_busy_start", o_tx_busy, 1'b1);
    check("tx_line_start", o_tx, 1'b0);
    if (rd_too) check("rx_rd_clear_b2b", o_rx_done, 1'b0);

    cyc = 0; done_cyc = 0; t_first = 0; bad_align = 0; prev = 1'b0;
    while (cyc < NBITS * BT + 2 * BAUD_DIV && done_cyc == 0) begin
      @(posedge clk);
      #1;
      cyc++;
      if (inject_cyc != 0 && cyc == inject_cyc) begin
        i_wr = 1'b1; i_wdata = inject_data; i_tx_start = 1'b1;
      end else begin
        i_wr = 1'b0; i_tx_start = 1'b0;
      end
      if (o_tx != prev) begin
        if (t_first == 0) t_first = cyc;
        else if ((cyc - t_first) % BT != 0) bad_align++;
      end
      prev = o_tx;
      if ((cyc - BT / 2) % BT == 0 && tx_exp_q.size() > 0)
        check("tx_bit", o_tx, tx_exp_q.pop_front());
      if (o_tx_done) done_cyc = cyc;
    end
    check("tx_done_window", (done_cyc >= NBITS * BT - BAUD_DIV + 1 && done_cyc <= NBITS * BT), 1);
    check("tx_done_phase", done_cyc - t_first, BT * (NBITS - j));
    check("tx_bit_align", bad_align, 0);
    check("tx_busy_done", o_tx_busy, 1'b0);
    check("tx_bits_left", tx_exp_q.size(), 0);
  endtask

  // Bit-bangs one frame onto the RX line; optionally holds i_rd through the stop bit.
  task automatic rx_send(input logic [NB-1:0] data, input logic stop_bit, input logic par_flip,
                         input logic rd_in_stop, output logic rose_o);
    logic seen_clear;
    rose_o = 1'b0;
    seen_clear = 1'b0;
    rx_drv = 1'b0;
    cycles(BT);
    for (int i = 0; i < NB; i++) begin
      rx_drv = data[i];
      cycles(BT);
    end
`ifdef UART_PARITY_EN
    rx_drv = (^data) ^ par_flip;
    cycles(BT);
`else
    rx_drv = rx_drv ^ par_flip ^ par_flip;
`endif
    rx_drv = stop_bit;
    if (rd_in_stop) i_rd = 1'b1;
    for (int c = 0; c < BT; c++) begin
      @(posedge clk);
      #1;
      if (rd_in_stop && i_rd) begin
        if (!o_rx_done) seen_clear = 1'b1;
        else if (seen_clear) begin
          rose_o = 1'b1;
          i_rd = 1'b0;
        end
      end
    end
    i_rd = 1'b0;
    rx_drv = 1'b1;
    cycles(BT / 4);
  endtask

  task automatic rx_check(input string tag);
    logic [NB-1:0] exp;
    if (rx_exp_q.size() == 0) begin
      check({tag, "_queue"}, 0, 1);
    end else begin
      exp = rx_exp_q.pop_front();
      check({tag, "_data"}, o_rx_data, exp);
      check({tag, "_done"}, o_rx_done, 1'b1);
    end
  endtask

  initial begin
    int cnt_done, cnt_low;
    i_wr = 1'b0; i_wdata = '0; i_tx_start = 1'b0; i_rd = 1'b0;
    rst = 1'b1;
    cycles(4);
    check("rst_tx", o_tx, 1'b1);
    check("rst_tx_done", o_tx_done, 1'b0);
    check("rst_tx_busy", o_tx_busy, 1'b0);
    check("rst_rx_data", o_rx_data, 8'h00);
    check("rst_rx_done", o_rx_done, 1'b0);
    check("rst_rx_overrun", o_rx_overrun, 1'b0);
    rst = 1'b0;
    cycles(3);

    // 0xA5 from the holding register; a start+write while busy must not disturb it
    loop_en = 1'b1;
    i_wr = 1'b1; i_wdata = 8'hA5;
    cycles(1);
    i_wr = 1'b0;
    rx_exp_q.push_back(8'hA5);
    tx_send(8'hA5, 1'b0, 1'b0, 300, 8'hFF);
    rx_check("loop_a5");
    cycles(3);
    check("tx_start_ignored_busy", o_tx_busy, 1'b0);
    check("tx_idle_line", o_tx, 1'b1);
    rd_pulse();
    check("rx_rd_clear", o_rx_done, 1'b0);

    // holding register took 0xFF while busy; then back-to-back with same-cycle write
    rx_exp_q.push_back(8'hFF);
    tx_send(8'hFF, 1'b0, 1'b0, 0, 8'h00);
    rx_check("loop_ff");
    rx_exp_q.push_back(8'h3C);
    tx_send(8'h3C, 1'b1, 1'b1, 0, 8'h00);
    rx_check("loop_3c");
    check("rx_no_overrun", o_rx_overrun, 1'b0);
    rd_pulse();
    check("rx_rd_clear_3c", o_rx_done, 1'b0);

    // glitch and framing error leave the last byte untouched
    loop_en = 1'b0;
    rx_drv = 1'b1;
    cycles(8);
    rx_drv = 1'b0;
    cycles(20);
    rx_drv = 1'b1;
    cycles(3 * BT);
    check("rx_glitch_done", o_rx_done, 1'b0);
    rx_send(8'h55, 1'b0, 1'b0, 1'b0, rose);
    cycles(BT);
    check("rx_frame_err_done", o_rx_done, 1'b0);
    check("rx_frame_err_data", o_rx_data, 8'h3C);
    rx_exp_q.push_back(8'h5A);
    rx_send(8'h5A, 1'b1, 1'b0, 1'b0, rose);
    rx_check("rx_recover");
    rd_pulse();

    // overrun, then a read coinciding with completion
    rx_exp_q.push_back(8'h11);
    rx_send(8'h11, 1'b1, 1'b0, 1'b0, rose);
    rx_check("rx_11");
    check("rx_overrun_first", o_rx_overrun, 1'b0);
    rx_exp_q.push_back(8'h22);
    rx_send(8'h22, 1'b1, 1'b0, 1'b0, rose);
    rx_check("rx_22");
    check("rx_overrun_set", o_rx_overrun, 1'b1);
    rx_exp_q.push_back(8'h33);
    rx_send(8'h33, 1'b1, 1'b0, 1'b1, rose);
    check("rd_coincide_rise", rose, 1'b1);
    cycles(2);
    rx_check("rx_33_rd_coincide");
    rd_pulse();

`ifdef UART_PARITY_EN
    loop_en = 1'b1;
    cycles(4);
    rx_exp_q.push_back(8'h07);
    tx_send(8'h07, 1'b1, 1'b0, 0, 8'h00);
    rx_check("par_loop_07");
    rd_pulse();
    loop_en = 1'b0;
    cycles(4);
    rx_send(8'h5A, 1'b1, 1'b1, 1'b0, rose);
    cycles(BT);
    check("par_err_done", o_rx_done, 1'b0);
    check("par_err_data", o_rx_data, 8'h07);
`endif

    // reset in the middle of DATA abandons the frame
    loop_en = 1'b1;
    cycles(4);
    i_wr = 1'b1; i_wdata = 8'hC3; i_tx_start = 1'b1;
    cycles(1);
    i_wr = 1'b0; i_tx_start = 1'b0;
    cycles(200);
    check("mid_busy", o_tx_busy, 1'b1);
    #3;
    rst = 1'b1;
    #1;
    check("rst_async_tx", o_tx, 1'b1);
    check("rst_async_busy", o_tx_busy, 1'b0);
    check("rst_async_overrun", o_rx_overrun, 1'b0);
    check("rst_async_rx_data", o_rx_data, 8'h00);
    cycles(3);
    rst = 1'b0;
    cnt_done = 0;
    cnt_low = 0;
    repeat (NBITS * BT + BT) begin
      @(posedge clk);
      #1;
      if (o_tx_done) cnt_done++;
      if (!o_tx) cnt_low++;
    end
    check("rst_no_tx_done", cnt_done, 0);
    check("rst_line_idle", cnt_low, 0);
    check("rst_no_rx_done", o_rx_done, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
